// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter with burst lock sharing one UART_ctrl transmit port
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 16,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       lock_abort
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);
  localparam logic [ID_W:0]    N_EXT    = (ID_W+1)'(N_REQ);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               lock_q, lock_d;
  logic               lock_abort_q, lock_abort_d;
  logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic [DATA_W-1:0]  req_word [N_REQ];
  logic [N_REQ-1:0]   eligible;
  logic               found;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    winner_next;
  logic [N_REQ-1:0]   ready_c;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_word[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // While locked, only the owner of the current message may be served.
  always_comb begin
    eligible = '0;
    if (lock_q) begin
      eligible[grant_id_q] = req_valid[grant_id_q];
    end else begin
      eligible = req_valid;
    end
  end

  always_comb begin
    logic [ID_W:0] sum;
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (sum >= N_EXT) begin
        sum = sum - N_EXT;
      end
      if (!found && eligible[sum[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = sum[ID_W-1:0];
      end
    end
  end

  assign winner_next = (winner == ID_LAST) ? '0 : winner + ID_W'(1);

  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    grant_id_d   = grant_id_q;
    rr_ptr_d     = rr_ptr_q;
    lock_d       = lock_q;
    lock_abort_d = 1'b0;
    tmo_cnt_d    = tmo_cnt_q;
    ready_c      = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          ready_c[winner] = 1'b1;
          out_data_d      = req_word[winner];
          grant_id_d      = winner;
          rr_ptr_d        = winner_next;
          lock_d          = ~req_last[winner];
          tmo_cnt_d       = '0;
          state_d         = S_SEND;
        end else if (lock_q) begin
          if (tmo_cnt_q == TMO_LAST) begin
            lock_d       = 1'b0;
            tmo_cnt_d    = '0;
            lock_abort_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
          end
        end
      end
      S_SEND: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      out_data_q   <= '0;
      grant_id_q   <= '0;
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      lock_abort_q <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      grant_id_q   <= grant_id_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      lock_abort_q <= lock_abort_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  // Reset must silence req_ready at once, not only after the next edge.
  assign req_ready  = rst ? '0 : ready_c;
  assign out_valid  = (state_q == S_SEND);
  assign out_data   = out_data_q;
  assign grant_id   = grant_id_q;
  assign busy       = (state_q != S_IDLE) | lock_q;
  assign lock_abort = lock_abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int W   = 16;
  localparam int TMO = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     grant_id;
  logic           busy;
  logic           lock_abort;

  logic [16:0]    rq [N][$];
  logic [17:0]    exp_q [$];
  logic [N-1:0]   snap;
  int             n_cmp = 0;
  int             n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .LOCK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .grant_id(grant_id),
    .busy(busy), .lock_abort(lock_abort)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic at_step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_req(input int i, input logic last, input logic [15:0] d);
    rq[i].push_back({last, d});
  endtask

  task automatic expect_word(input logic [1:0] g, input logic [15:0] d);
    exp_q.push_back({g, d});
  endtask

  task automatic wait_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && rq[0].size() == 0 && rq[1].size() == 0 &&
          rq[2].size() == 0 && rq[3].size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  // Requester models: present queue heads, retire a word after the edge that accepted it.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      snap = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (snap[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      end
      for (int i = 0; i < N; i++) begin
        if (rq[i].size() > 0) begin
          req_valid[i]         = 1'b1;
          req_data[i*W +: W]   = rq[i][0][15:0];
          req_last[i]          = rq[i][0][16];
        end else begin
          req_valid[i]         = 1'b0;
          req_data[i*W +: W]   = '0;
          req_last[i]          = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every accepted output word against the scoreboard.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: got grant %0d data %h expected no word", grant_id, out_data);
          end else begin
            e = exp_q.pop_front();
            chk("sb_data", 32'(out_data), 32'(e[15:0]));
            chk("sb_grant", 32'(grant_id), 32'(e[17:16]));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  got;
    rst       = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lock_abort", 32'(lock_abort), 32'd0);
    at_step();
    rst = 1'b0;

    // Reset in the middle of a locked SEND with the sink stalled
    expect_word(2'd1, 16'hA5A5);
    push_req(1, 1'b0, 16'hA5A5);
    wait_valid("t1_valid");
    push_req(3, 1'b1, 16'h3333);
    #2 rst = 1'b1;
    #1;
    chk("t1_out_valid", 32'(out_valid), 32'd0);
    chk("t1_req_ready", 32'(req_ready), 32'd0);
    chk("t1_lock_abort", 32'(lock_abort), 32'd0);
    chk("t1_grant_id", 32'(grant_id), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    exp_q.delete();
    expect_word(2'd3, 16'h3333);
    at_step();
    chk("t1_ready_in_rst", 32'(req_ready), 32'd0);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    wait_drain("t1_drain");

    // Single word from requester 2
    at_step();
    expect_word(2'd2, 16'h4F3E);
    push_req(2, 1'b1, 16'h4F3E);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ready != 0) break;
    end
    chk("t2_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    chk("t2_ready_drop", 32'(req_ready), 32'd0);
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t2_out_data", 32'(out_data), 32'h4F3E);
    chk("t2_grant_id", 32'(grant_id), 32'd2);
    wait_drain("t2_drain");
    // rr_ptr is now 3: requester 3 beats requester 0
    at_step();
    expect_word(2'd3, 16'h0303);
    expect_word(2'd0, 16'h0300);
    push_req(0, 1'b1, 16'h0300);
    push_req(3, 1'b1, 16'h0303);
    wait_drain("t2_rr_drain");

    // Round robin from a fresh reset, all requesters continuously valid
    at_step();
    rst = 1'b1;
    at_step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        expect_word(2'(i), 16'hC000 | 16'(i << 4) | 16'(k));
        push_req(i, 1'b1, 16'hC000 | 16'(i << 4) | 16'(k));
      end
    end
    wait_drain("t3_drain");

    // Burst lock: move rr_ptr to 1, then requester 1 sends a 3-word message
    at_step();
    expect_word(2'd0, 16'h0A0A);
    push_req(0, 1'b1, 16'h0A0A);
    wait_drain("t4_pre_drain");
    at_step();
    expect_word(2'd1, 16'h1111);
    expect_word(2'd1, 16'h2222);
    expect_word(2'd1, 16'h3333);
    expect_word(2'd3, 16'h3B3B);
    expect_word(2'd0, 16'h0B0B);
    push_req(1, 1'b0, 16'h1111);
    push_req(1, 1'b0, 16'h2222);
    push_req(1, 1'b1, 16'h3333);
    push_req(0, 1'b1, 16'h0B0B);
    push_req(3, 1'b1, 16'h3B3B);
    wait_drain("t4_drain");

    // Back-pressure: 20 stalled cycles
    at_step();
    out_ready = 1'b0;
    expect_word(2'd2, 16'h5A5A);
    push_req(2, 1'b1, 16'h5A5A);
    wait_valid("t5_valid");
    expect_word(2'd0, 16'h0C0C);
    push_req(0, 1'b1, 16'h0C0C);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("t5_hold", {out_valid, out_data, req_ready, grant_id}, {1'b1, 16'h5A5A, 4'b0000, 2'd2});
    end
    at_step();
    out_ready = 1'b1;
    wait_drain("t5_drain");

    // Lock timeout: requester 0 abandons its message
    at_step();
    expect_word(2'd0, 16'h6001);
    push_req(0, 1'b0, 16'h6001);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("t6_first_word", 32'(got), 32'd1);
    expect_word(2'd2, 16'h6002);
    push_req(2, 1'b1, 16'h6002);
    n   = 0;
    got = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (lock_abort) begin
        got = 1'b1;
        break;
      end
      n++;
      chk("t6_locked", {req_ready, busy}, {4'b0000, 1'b1});
    end
    chk("t6_abort_seen", 32'(got), 32'd1);
    chk("t6_idle_cycles", 32'(n), 32'd8);
    chk("t6_ready_after", 32'(req_ready), 32'h4);
    @(negedge clk);
    chk("t6_abort_width", 32'(lock_abort), 32'd0);
    chk("t6_grant_valid", {out_valid, grant_id}, {1'b1, 2'd2});
    wait_drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
